// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state codes and default timing constants for the alarm controller
package alarm_pkg;
  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;
  localparam int DEF_EXIT_SECS  = 10;
  localparam int DEF_ENTRY_SECS = 8;
  localparam int DEF_ALARM_SECS = 60;
  localparam int SIM_TICK_DIV   = 4;
endpackage

// File: rtl/alarm_arm_controller_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr
// ports: clk, rst_n (async low), clr (restart count at 0), tick (terminal-count pulse)
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  if (TICK_DIV < 2) begin : g_bad_cfg
    $error("tick_prescaler: TICK_DIV must be at least 2");
  end
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/alarm_arm_controller.sv
// alarm_arm_controller: arm/disarm FSM with exit, entry and alarm countdowns driving the siren enable
// ports: clk, rst_n (async low), arm_req/disarm_ok (keypad pulses), door/pir (async sensors),
//        aux (siren enable), armed_led, state_o (state code), secs_left (active countdown)
module alarm_arm_controller
  import alarm_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int EXIT_SECS  = DEF_EXIT_SECS,
  parameter int ENTRY_SECS = DEF_ENTRY_SECS,
  parameter int ALARM_SECS = DEF_ALARM_SECS,
  parameter int N_PIR      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_req,
  input  logic             disarm_ok,
  input  logic             door,
  input  logic [N_PIR-1:0] pir,
  output logic             aux,
  output logic             armed_led,
  output logic [2:0]       state_o,
  output logic [7:0]       secs_left
);
  if (EXIT_SECS < 1 || EXIT_SECS > 255 || ENTRY_SECS < 1 || ENTRY_SECS > 255 ||
      ALARM_SECS < 1 || ALARM_SECS > 255) begin : g_bad_cfg
    $error("alarm_arm_controller: second counts must be in 1..255");
  end
  state_t           state, nxt;
  logic [N_PIR:0]   sync1, sync2;
  logic [N_PIR-1:0] pir_s;
  logic             door_s, tick, expire;
  logic [7:0]       load;
  for (genvar i = 0; i <= N_PIR; i++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sync1[i] <= 1'b0;
        sync2[i] <= 1'b0;
      end else begin
        sync1[i] <= i == 0 ? door : pir[i-1];
        sync2[i] <= sync1[i];
      end
  end
  assign {pir_s, door_s} = sync2;
  // prescaler restarts on every transition so the first second of a countdown is full length
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (nxt != state),
    .tick (tick)
  );
  assign expire  = tick && secs_left == 8'd1;
  assign state_o = state;
  assign load    = nxt == ST_EXIT  ? 8'(EXIT_SECS)  :
                   nxt == ST_ENTRY ? 8'(ENTRY_SECS) :
                   nxt == ST_ALARM ? 8'(ALARM_SECS) : 8'd0;
  // disarm_ok is tested first everywhere it has meaning, so it beats expiry and sensors
  always_comb begin
    nxt = ST_DISARMED;
    case (state)
      ST_DISARMED: nxt = arm_req ? ST_EXIT : ST_DISARMED;
      ST_EXIT:     nxt = disarm_ok ? ST_DISARMED : expire ? ST_ARMED : ST_EXIT;
      ST_ARMED:    nxt = disarm_ok ? ST_DISARMED : |pir_s ? ST_ALARM : door_s ? ST_ENTRY : ST_ARMED;
      ST_ENTRY:    nxt = disarm_ok ? ST_DISARMED : expire ? ST_ALARM : ST_ENTRY;
      ST_ALARM:    nxt = disarm_ok ? ST_DISARMED : expire ? ST_ARMED : ST_ALARM;
      default:     nxt = ST_DISARMED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_DISARMED;
      aux       <= 1'b0;
      armed_led <= 1'b0;
      secs_left <= 8'd0;
    end else begin
      state     <= nxt;
      aux       <= nxt == ST_ALARM;
      armed_led <= nxt != ST_DISARMED;
      secs_left <= nxt != state ? load : secs_left - 8'(tick && secs_left != 8'd0);
    end
endmodule

// File: tb/tb_alarm_arm_controller.sv
// tb_alarm_arm_controller: randomized and directed scoreboard bench against a cycle-count reference model
module tb_alarm_arm_controller;
  import alarm_pkg::*;
  localparam int TD = SIM_TICK_DIV;
  localparam int EX = 3;
  localparam int EN = 2;
  localparam int AL = 3;
  logic       clk = 1'b0, rst_n = 1'b0, arm_req = 1'b0, disarm_ok = 1'b0, door = 1'b0;
  logic [1:0] pir = 2'b00;
  logic       aux, armed_led;
  logic [2:0] state_o;
  logic [7:0] secs_left;
  alarm_arm_controller #(
    .TICK_DIV(TD), .EXIT_SECS(EX), .ENTRY_SECS(EN), .ALARM_SECS(AL), .N_PIR(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm_req(arm_req), .disarm_ok(disarm_ok), .door(door), .pir(pir),
    .aux(aux), .armed_led(armed_led), .state_o(state_o), .secs_left(secs_left)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] st;
    logic       aux;
    logic       led;
    logic [7:0] secs;
  } exp_t;
  exp_t       exp_q[$];
  int         n_cmp = 0, n_err = 0;
  int         m_st = 0, m_el = 0;
  logic [2:0] hist[$] = '{3'd0, 3'd0};
  function automatic int dur(int s);
    return s == 1 ? EX : s == 3 ? EN : s == 4 ? AL : 0;
  endfunction
  function automatic exp_t expect_now();
    exp_t e;
    e.st   = 3'(m_st);
    e.aux  = m_st == 4;
    e.led  = m_st != 0;
    e.secs = dur(m_st) > 0 ? 8'(dur(m_st) - m_el / TD) : 8'd0;
    return e;
  endfunction
  function automatic void model_reset();
    m_st = 0;
    m_el = 0;
    hist = '{3'd0, 3'd0};
  endfunction
  function automatic void model_step(bit a, bit d, logic [2:0] raw);
    logic [2:0] s;
    int         nx;
    bit         ex;
    s = hist.pop_front();
    hist.push_back(raw);
    nx = m_st;
    ex = dur(m_st) > 0 && m_el == dur(m_st) * TD - 1;
    case (m_st)
      0: if (a) nx = 1;
      1: nx = d ? 0 : ex ? 2 : 1;
      2: nx = d ? 0 : s[2:1] != 2'b00 ? 4 : s[0] ? 3 : 2;
      3: nx = d ? 0 : ex ? 4 : 3;
      4: nx = d ? 0 : ex ? 2 : 4;
      default: nx = 0;
    endcase
    if (nx != m_st) begin
      m_st = nx;
      m_el = 0;
    end else m_el++;
  endfunction
  task automatic step(bit a, bit d, bit dr, logic [1:0] p);
    @(negedge clk);
    rst_n = 1'b1; arm_req = a; disarm_ok = d; door = dr; pir = p;
    model_step(a, d, {p, dr});
    exp_q.push_back(expect_now());
  endtask
  task automatic rst_step();
    @(negedge clk);
    rst_n = 1'b0; arm_req = 1'b0; disarm_ok = 1'b0; door = 1'b0; pir = 2'b00;
    model_reset();
    exp_q.push_back(expect_now());
  endtask
  task automatic run_until(int target, bit dr, int limit);
    int n = 0;
    while (m_st != target && n < limit) begin
      step(0, 0, dr, 2'b00);
      n++;
    end
    if (m_st != target) begin
      n_cmp++; n_err++;
      $display("FAIL wait_state: model reached %0d, want %0d within %0d cycles", m_st, target, limit);
    end
  endtask
  task automatic async_reset_check();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (aux !== 1'b0 || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got aux=%b state=%0d, want aux=0 state=0", aux, state_o);
    end
  endtask
  task automatic force_illegal();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1; arm_req = 1'b0; disarm_ok = 1'b0; door = 1'b0; pir = 2'b00;
    force dut.state = state_t'(3'd6);
    void'(hist.pop_front());
    hist.push_back(3'd0);
    m_st = 0;
    m_el = 0;
    e = '{st: 3'd6, aux: 1'b0, led: 1'b0, secs: 8'd0};
    exp_q.push_back(e);
    @(posedge clk);
    #2 release dut.state;
  endtask
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = exp_t'({state_o, aux, armed_led, secs_left});
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t: got st=%0d aux=%b led=%b secs=%0d, want st=%0d aux=%b led=%b secs=%0d",
                 $time, g.st, g.aux, g.led, g.secs, e.st, e.aux, e.led, e.secs);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bit rd = 1'b0;
    repeat (3) rst_step();
    repeat (50) step(0, 0, 1, 2'b11);
    step(1, 0, 0, 2'b00);
    repeat (14) step(0, 0, 0, 2'b00);
    repeat (29) step(0, 0, 1, 2'b00);
    step(0, 1, 1, 2'b00);
    repeat (4) step(0, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00);
    run_until(2, 0, 20);
    step(0, 0, 1, 2'b00);
    run_until(3, 0, 5);
    for (int n = 0; n < 10 && m_el != EN * TD - 1; n++) step(0, 0, 0, 2'b00);
    step(0, 1, 0, 2'b00);
    repeat (3) step(0, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00);
    run_until(2, 0, 20);
    step(0, 0, 0, 2'b10);
    repeat (6) step(0, 0, 0, 2'b00);
    async_reset_check();
    repeat (2) rst_step();
    repeat (3) step(0, 0, 0, 2'b00);
    step(1, 0, 0, 2'b00);
    run_until(2, 0, 20);
    step(1, 0, 0, 2'b00);
    step(0, 0, 0, 2'b00);
    force_illegal();
    repeat (3) step(0, 0, 0, 2'b00);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) rd = ~rd;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, rd,
           $urandom_range(0, 29) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
